// File: rtl/toy_bus_dmerge2ch.sv
// Two-initiator request merge with round-robin arbitration and in-order ack routing.
// Define TOY_BUS_DMERGE2CH_OUT_REG_EN to register the merged request output.
module toy_bus_dmerge2ch #(
   parameter int ORD_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in0_req_vld,
   output logic         in0_req_rdy,
   input  logic [31:0]  in0_req_addr,
   input  logic [31:0]  in0_req_strb,
   input  logic [255:0] in0_req_data,
   input  logic         in0_req_opcode,
   input  logic [3:0]   in0_req_src_id,
   input  logic [3:0]   in0_req_tgt_id,
   input  logic [31:0]  in0_req_sideband,
   input  logic         in1_req_vld,
   output logic         in1_req_rdy,
   input  logic [31:0]  in1_req_addr,
   input  logic [31:0]  in1_req_strb,
   input  logic [255:0] in1_req_data,
   input  logic         in1_req_opcode,
   input  logic [3:0]   in1_req_src_id,
   input  logic [3:0]   in1_req_tgt_id,
   input  logic [31:0]  in1_req_sideband,
   output logic         out0_req_vld,
   input  logic         out0_req_rdy,
   output logic [31:0]  out0_req_addr,
   output logic [31:0]  out0_req_strb,
   output logic [255:0] out0_req_data,
   output logic         out0_req_opcode,
   output logic [3:0]   out0_req_src_id,
   output logic [3:0]   out0_req_tgt_id,
   output logic [31:0]  out0_req_sideband,
   input  logic         out0_ack_vld,
   output logic         out0_ack_rdy,
   input  logic         out0_ack_opcode,
   input  logic [255:0] out0_ack_data,
   input  logic [31:0]  out0_ack_sideband,
   input  logic [3:0]   out0_ack_src_id,
   input  logic [3:0]   out0_ack_tgt_id,
   output logic         in0_ack_vld,
   input  logic         in0_ack_rdy,
   output logic         in0_ack_opcode,
   output logic [255:0] in0_ack_data,
   output logic [31:0]  in0_ack_sideband,
   output logic [3:0]   in0_ack_src_id,
   output logic [3:0]   in0_ack_tgt_id,
   output logic         in1_ack_vld,
   input  logic         in1_ack_rdy,
   output logic         in1_ack_opcode,
   output logic [255:0] in1_ack_data,
   output logic [31:0]  in1_ack_sideband,
   output logic [3:0]   in1_ack_src_id,
   output logic [3:0]   in1_ack_tgt_id
);

   localparam int PW = $clog2(ORD_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = 361;
   localparam logic [CW-1:0] FULL_CNT = CW'(ORD_DEPTH);

   logic [RW-1:0] in0_pl_s, in1_pl_s, sel_pl_s, out_pl_s;
   logic          en_s, sel_vld_s, gnt_vld_s, gnt_idx_s, arb_en_s;
   logic          lock_s, lock_idx_s, push_s, pop_s, can_push_s;
   logic          empty_s, full_s, head_s, hd_rdy_s;
   logic          prio_q, prio_d;
   logic [ORD_DEPTH-1:0] ord_q;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign en_s     = ~rst;
   assign in0_pl_s = {in0_req_addr, in0_req_strb, in0_req_data, in0_req_opcode,
                      in0_req_src_id, in0_req_tgt_id, in0_req_sideband};
   assign in1_pl_s = {in1_req_addr, in1_req_strb, in1_req_data, in1_req_opcode,
                      in1_req_src_id, in1_req_tgt_id, in1_req_sideband};
   assign {out0_req_addr, out0_req_strb, out0_req_data, out0_req_opcode,
           out0_req_src_id, out0_req_tgt_id, out0_req_sideband} = out_pl_s;

   assign sel_vld_s  = gnt_idx_s ? in1_req_vld : in0_req_vld;
   assign sel_pl_s   = gnt_idx_s ? in1_pl_s : in0_pl_s;
   assign empty_s    = (cnt_q == {CW{1'b0}});
   assign full_s     = (cnt_q == FULL_CNT);
   assign can_push_s = ~full_s | pop_s;

   // round-robin grant selection, overridden by a held (stalled) grant
   always_comb begin
      gnt_vld_s = 1'b0;
      gnt_idx_s = 1'b0;
      if (lock_s) begin
         gnt_vld_s = 1'b1;
         gnt_idx_s = lock_idx_s;
      end else if (arb_en_s) begin
         case ({in1_req_vld, in0_req_vld})
            2'b11:   begin gnt_vld_s = 1'b1; gnt_idx_s = prio_q; end
            2'b01:   begin gnt_vld_s = 1'b1; gnt_idx_s = 1'b0;   end
            2'b10:   begin gnt_vld_s = 1'b1; gnt_idx_s = 1'b1;   end
            default: begin gnt_vld_s = 1'b0; gnt_idx_s = 1'b0;   end
         endcase
      end else begin
         gnt_vld_s = 1'b0;
         gnt_idx_s = 1'b0;
      end
   end

`ifdef TOY_BUS_DMERGE2CH_OUT_REG_EN
   logic          stg_vld_q, stg_vld_d, load_s;
   logic [RW-1:0] stg_pl_q, stg_pl_d;

   assign lock_s       = 1'b0;
   assign lock_idx_s   = 1'b0;
   assign arb_en_s     = (~stg_vld_q | out0_req_rdy) & can_push_s & en_s;
   assign in0_req_rdy  = gnt_vld_s & ~gnt_idx_s;
   assign in1_req_rdy  = gnt_vld_s & gnt_idx_s;
   assign load_s       = gnt_vld_s & sel_vld_s;
   assign push_s       = load_s;
   assign out0_req_vld = stg_vld_q & en_s;
   assign out_pl_s     = stg_pl_q;

   // output stage: load on grant, empty when drained
   always_comb begin
      stg_vld_d = stg_vld_q;
      stg_pl_d  = stg_pl_q;
      if (load_s) begin
         stg_vld_d = 1'b1;
         stg_pl_d  = sel_pl_s;
      end else if (out0_req_rdy) begin
         stg_vld_d = 1'b0;
      end else begin
         stg_vld_d = stg_vld_q;
      end
   end

   // output stage registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld_q <= 1'b0;
         stg_pl_q  <= {RW{1'b0}};
      end else begin
         stg_vld_q <= stg_vld_d;
         stg_pl_q  <= stg_pl_d;
      end
   end
`else
   logic lock_q, lock_idx_q;

   assign lock_s       = lock_q;
   assign lock_idx_s   = lock_idx_q;
   assign arb_en_s     = can_push_s & en_s;
   assign out0_req_vld = gnt_vld_s & sel_vld_s & en_s;
   assign out_pl_s     = sel_pl_s;
   assign in0_req_rdy  = gnt_vld_s & ~gnt_idx_s & out0_req_rdy & en_s;
   assign in1_req_rdy  = gnt_vld_s & gnt_idx_s & out0_req_rdy & en_s;
   assign push_s       = out0_req_vld & out0_req_rdy;

   // hold the grant while downstream back-pressures an offered request
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q     <= 1'b0;
         lock_idx_q <= 1'b0;
      end else begin
         lock_q     <= out0_req_vld & ~out0_req_rdy;
         lock_idx_q <= gnt_idx_s;
      end
   end
`endif

   assign head_s       = ord_q[rd_ptr_q];
   assign hd_rdy_s     = head_s ? in1_ack_rdy : in0_ack_rdy;
   assign out0_ack_rdy = ~empty_s & hd_rdy_s & en_s;
   assign in0_ack_vld  = out0_ack_vld & ~empty_s & ~head_s & en_s;
   assign in1_ack_vld  = out0_ack_vld & ~empty_s & head_s & en_s;
   assign pop_s        = out0_ack_vld & out0_ack_rdy;

   assign in0_ack_opcode   = out0_ack_opcode;
   assign in0_ack_data     = out0_ack_data;
   assign in0_ack_sideband = out0_ack_sideband;
   assign in0_ack_src_id   = out0_ack_src_id;
   assign in0_ack_tgt_id   = out0_ack_tgt_id;
   assign in1_ack_opcode   = out0_ack_opcode;
   assign in1_ack_data     = out0_ack_data;
   assign in1_ack_sideband = out0_ack_sideband;
   assign in1_ack_src_id   = out0_ack_src_id;
   assign in1_ack_tgt_id   = out0_ack_tgt_id;

   // order FIFO pointers, occupancy and priority next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      prio_d   = prio_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         prio_d   = ~gnt_idx_s;
      end else begin
         wr_ptr_d = wr_ptr_q;
         prio_d   = prio_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // order FIFO and arbitration state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         prio_q   <= 1'b0;
         ord_q    <= {ORD_DEPTH{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         prio_q   <= prio_d;
         if (push_s) begin
            ord_q[wr_ptr_q] <= gnt_idx_s;
         end else begin
            ord_q <= ord_q;
         end
      end
   end

endmodule

// File: tb/tb_toy_bus_dmerge2ch.sv
// Directed self-checking bench for toy_bus_dmerge2ch (default combinational request path).
module tb_toy_bus_dmerge2ch;

   logic         clk = 1'b0;
   logic         rst;
   logic         in0_req_vld, in0_req_rdy, in1_req_vld, in1_req_rdy;
   logic [31:0]  in0_req_addr, in0_req_strb, in0_req_sideband;
   logic [31:0]  in1_req_addr, in1_req_strb, in1_req_sideband;
   logic [255:0] in0_req_data, in1_req_data;
   logic         in0_req_opcode, in1_req_opcode;
   logic [3:0]   in0_req_src_id, in0_req_tgt_id, in1_req_src_id, in1_req_tgt_id;
   logic         out0_req_vld, out0_req_rdy, out0_req_opcode;
   logic [31:0]  out0_req_addr, out0_req_strb, out0_req_sideband;
   logic [255:0] out0_req_data;
   logic [3:0]   out0_req_src_id, out0_req_tgt_id;
   logic         out0_ack_vld, out0_ack_rdy, out0_ack_opcode;
   logic [255:0] out0_ack_data;
   logic [31:0]  out0_ack_sideband;
   logic [3:0]   out0_ack_src_id, out0_ack_tgt_id;
   logic         in0_ack_vld, in0_ack_rdy, in0_ack_opcode;
   logic [255:0] in0_ack_data;
   logic [31:0]  in0_ack_sideband;
   logic [3:0]   in0_ack_src_id, in0_ack_tgt_id;
   logic         in1_ack_vld, in1_ack_rdy, in1_ack_opcode;
   logic [255:0] in1_ack_data;
   logic [31:0]  in1_ack_sideband;
   logic [3:0]   in1_ack_src_id, in1_ack_tgt_id;

   int n_tests = 0;
   int n_fail  = 0;

   toy_bus_dmerge2ch #(.ORD_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in0_req_vld(in0_req_vld), .in0_req_rdy(in0_req_rdy), .in0_req_addr(in0_req_addr),
      .in0_req_strb(in0_req_strb), .in0_req_data(in0_req_data), .in0_req_opcode(in0_req_opcode),
      .in0_req_src_id(in0_req_src_id), .in0_req_tgt_id(in0_req_tgt_id), .in0_req_sideband(in0_req_sideband),
      .in1_req_vld(in1_req_vld), .in1_req_rdy(in1_req_rdy), .in1_req_addr(in1_req_addr),
      .in1_req_strb(in1_req_strb), .in1_req_data(in1_req_data), .in1_req_opcode(in1_req_opcode),
      .in1_req_src_id(in1_req_src_id), .in1_req_tgt_id(in1_req_tgt_id), .in1_req_sideband(in1_req_sideband),
      .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy), .out0_req_addr(out0_req_addr),
      .out0_req_strb(out0_req_strb), .out0_req_data(out0_req_data), .out0_req_opcode(out0_req_opcode),
      .out0_req_src_id(out0_req_src_id), .out0_req_tgt_id(out0_req_tgt_id), .out0_req_sideband(out0_req_sideband),
      .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy), .out0_ack_opcode(out0_ack_opcode),
      .out0_ack_data(out0_ack_data), .out0_ack_sideband(out0_ack_sideband),
      .out0_ack_src_id(out0_ack_src_id), .out0_ack_tgt_id(out0_ack_tgt_id),
      .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(in0_ack_rdy), .in0_ack_opcode(in0_ack_opcode),
      .in0_ack_data(in0_ack_data), .in0_ack_sideband(in0_ack_sideband),
      .in0_ack_src_id(in0_ack_src_id), .in0_ack_tgt_id(in0_ack_tgt_id),
      .in1_ack_vld(in1_ack_vld), .in1_ack_rdy(in1_ack_rdy), .in1_ack_opcode(in1_ack_opcode),
      .in1_ack_data(in1_ack_data), .in1_ack_sideband(in1_ack_sideband),
      .in1_ack_src_id(in1_ack_src_id), .in1_ack_tgt_id(in1_ack_tgt_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ack routing check: which upstream port should see the ack this cycle
   task automatic chk_ack(input string tag, input logic port);
      chk({tag, "_in0_vld"}, in0_ack_vld, !port);
      chk({tag, "_in1_vld"}, in1_ack_vld, port);
      chk({tag, "_out_rdy"}, out0_ack_rdy, 1'b1);
   endtask

   initial begin
      logic [3:0] exp_src;
      logic       exp_port [3];
      rst = 1'b1;
      in0_req_vld = 1'b1; in1_req_vld = 1'b0;
      in0_req_addr = 32'h0; in0_req_strb = 32'hFFFF_FFFF; in0_req_data = 256'h11;
      in0_req_opcode = 1'b1; in0_req_src_id = 4'h1; in0_req_tgt_id = 4'h7; in0_req_sideband = 32'h0;
      in1_req_addr = 32'h0; in1_req_strb = 32'h0000_FFFF; in1_req_data = 256'h22;
      in1_req_opcode = 1'b0; in1_req_src_id = 4'h2; in1_req_tgt_id = 4'h7; in1_req_sideband = 32'h5;
      out0_req_rdy = 1'b1;
      out0_ack_vld = 1'b1; out0_ack_opcode = 1'b0; out0_ack_data = 256'h0;
      out0_ack_sideband = 32'h0; out0_ack_src_id = 4'h7; out0_ack_tgt_id = 4'h1;
      in0_ack_rdy = 1'b1; in1_ack_rdy = 1'b1;
      tick(); tick();
      chk("rst_out_vld", out0_req_vld, 1'b0);
      chk("rst_in0_rdy", in0_req_rdy, 1'b0);
      chk("rst_ack_rdy", out0_ack_rdy, 1'b0);
      chk("rst_in0_ack_vld", in0_ack_vld, 1'b0);

      // alternating grants with both ports requesting
      tick();
      rst = 1'b0; out0_ack_vld = 1'b0;
      in0_req_addr = 32'h100; in1_req_vld = 1'b1; in1_req_addr = 32'h200;
      for (int i = 0; i < 4; i++) begin
         #1;
         exp_src = (i % 2 == 1) ? 4'h2 : 4'h1;
         chk("alt_vld", out0_req_vld, 1'b1);
         chk("alt_src", out0_req_src_id, exp_src);
         chk("alt_in0_rdy", in0_req_rdy, (i % 2 == 0));
         chk("alt_in1_rdy", in1_req_rdy, (i % 2 == 1));
         tick();
      end
      chk("full_out_vld", out0_req_vld, 1'b0);
      chk("full_in0_rdy", in0_req_rdy, 1'b0);
      chk("full_in1_rdy", in1_req_rdy, 1'b0);
      in0_req_vld = 1'b0; in1_req_vld = 1'b0;
      out0_ack_vld = 1'b1; out0_ack_data = 256'hA;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_ack("alt_ack", (i % 2 == 1));
         tick();
      end
      chk("alt_empty_rdy", out0_ack_rdy, 1'b0);
      chk("alt_empty_vld", in0_ack_vld | in1_ack_vld, 1'b0);
      out0_ack_vld = 1'b0;

      // one port-0 grant moves priority to port 1
      in0_req_vld = 1'b1; in0_req_addr = 32'h50;
      #1;
      chk("pre_in0_rdy", in0_req_rdy, 1'b1);
      tick();
      // back-pressure hold: port 0 stays granted though port 1 has priority
      in0_req_addr = 32'h1000; out0_req_rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i == 2) begin
            in1_req_vld = 1'b1; in1_req_addr = 32'h2000;
         end
         #1;
         chk("hold_vld", out0_req_vld, 1'b1);
         chk("hold_addr", out0_req_addr, 32'h1000);
         chk("hold_in1_rdy", in1_req_rdy, 1'b0);
         tick();
      end
      out0_req_rdy = 1'b1;
      #1;
      chk("hold_rel_in0_rdy", in0_req_rdy, 1'b1);
      chk("hold_rel_addr", out0_req_addr, 32'h1000);
      tick();
      in0_req_vld = 1'b0;
      #1;
      chk("hold_p1_addr", out0_req_addr, 32'h2000);
      chk("hold_p1_rdy", in1_req_rdy, 1'b1);
      tick();
      in1_req_vld = 1'b0;
      exp_port[0] = 1'b0; exp_port[1] = 1'b0; exp_port[2] = 1'b1;
      out0_ack_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_ack("hold_ack", exp_port[i]);
         tick();
      end
      chk("hold_empty_rdy", out0_ack_rdy, 1'b0);
      out0_ack_vld = 1'b0;

      // fill order FIFO with ports 1,0,0,1
      in1_req_vld = 1'b1; #1; chk("fill0", in1_req_rdy, 1'b1); tick();
      in1_req_vld = 1'b0; in0_req_vld = 1'b1; #1; chk("fill1", in0_req_rdy, 1'b1); tick();
      #1; chk("fill2", in0_req_rdy, 1'b1); tick();
      in0_req_vld = 1'b0; in1_req_vld = 1'b1; #1; chk("fill3", in1_req_rdy, 1'b1); tick();
      in0_req_vld = 1'b1;
      #1;
      chk("stall_in0_rdy", in0_req_rdy, 1'b0);
      chk("stall_in1_rdy", in1_req_rdy, 1'b0);
      chk("stall_out_vld", out0_req_vld, 1'b0);
      tick();
      // first ack goes to port 1; its pop lets a push happen while full
      out0_ack_vld = 1'b1; out0_ack_data = 256'hA;
      #1;
      chk_ack("first_ack", 1'b1);
      chk("first_ack_data", in1_ack_data, 256'hA);
      chk("pushpop_in0_rdy", in0_req_rdy, 1'b1);
      chk("pushpop_in1_rdy", in1_req_rdy, 1'b0);
      chk("pushpop_out_vld", out0_req_vld, 1'b1);
      tick();
      out0_ack_vld = 1'b0; in1_req_vld = 1'b0;
      #1;
      chk("still_full_vld", out0_req_vld, 1'b0);
      in0_req_vld = 1'b0;
      tick();

      // remaining acks in order 0,0,1,0 with a port-0 stall first
      out0_ack_vld = 1'b1; out0_ack_data = 256'hB; in0_ack_rdy = 1'b0;
      #1;
      chk("stall_ack_vld0", in0_ack_vld, 1'b1);
      chk("stall_ack_vld1", in1_ack_vld, 1'b0);
      chk("stall_ack_rdy", out0_ack_rdy, 1'b0);
      tick();
      in0_ack_rdy = 1'b1;
      #1;
      chk_ack("ackB", 1'b0);
      chk("ackB_data", in0_ack_data, 256'hB);
      tick();
      out0_ack_data = 256'hC; #1; chk_ack("ackC", 1'b0); tick();
      out0_ack_data = 256'hD; #1; chk_ack("ackD", 1'b1);
      chk("ackD_data", in1_ack_data, 256'hD); tick();
      out0_ack_data = 256'hE; #1; chk_ack("ackE", 1'b0); tick();
      chk("ack_empty_rdy", out0_ack_rdy, 1'b0);
      out0_ack_vld = 1'b0;

      // reset with two outstanding routes and a pending request
      in0_req_vld = 1'b1; in1_req_vld = 1'b1;
      tick(); tick();
      out0_req_rdy = 1'b0;
      #1;
      chk("pend_vld", out0_req_vld, 1'b1);
      chk("pend_src", out0_req_src_id, 4'h2);
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_vld", out0_req_vld, 1'b0);
      chk("mid_rst_rdy", in1_req_rdy, 1'b0);
      tick();
      rst = 1'b0; out0_req_rdy = 1'b1; out0_ack_vld = 1'b1; out0_ack_data = 256'hF;
      #1;
      chk("post_rst_ack_rdy", out0_ack_rdy, 1'b0);
      chk("post_rst_ack_vld", in0_ack_vld | in1_ack_vld, 1'b0);
      chk("post_rst_src", out0_req_src_id, 4'h1);
      chk("post_rst_in0_rdy", in0_req_rdy, 1'b1);
      tick();
      in0_req_vld = 1'b0; in1_req_vld = 1'b0; out0_ack_vld = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
